// File: rtl/uartbone_bridge.sv
// UART-to-Wishbone bridge: 8N1 byte commands drive single Wishbone master cycles; read data is returned over UART.
// Optional ack watchdog enabled by defining UARTBONE_TIMEOUT_EN.
module uartbone_bridge #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 30,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    output logic                  uart_tx,
    output logic [ADDR_W-1:0]     wb_adr,
    output logic [DATA_W-1:0]     wb_dat_w,
    input  logic [DATA_W-1:0]     wb_dat_r,
    output logic [DATA_W/8-1:0]   wb_sel,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    input  logic                  wb_ack
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned CW    = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam logic [7:0]  CMD_WR = 8'h01;
    localparam logic [7:0]  CMD_RD = 8'h02;

    if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > 64 || ADDR_W < 1 || ADDR_W > 32 ||
        TIMEOUT < 1 || CLKS_PER_BIT < 4) begin : g_bad_param
        $error("uartbone_bridge: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_ADDR, S_WDATA, S_WB_WR, S_WB_RD, S_TX_DATA
    } state_t;

    state_t state_q, state_d;

    assign wb_sel = '1;

    // Receiver: synchroniser, start-edge detect, mid-bit sampling
    logic          rx_meta, rx_s, rx_prev;
    logic          rx_busy, rx_valid, rx_ferr;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            rx_busy  <= 1'b0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_meta  <= uart_rx;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (!rx_busy) begin
                if (rx_prev && !rx_s) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_bit  <= '0;
                end
            end else begin
                if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    rx_cnt <= '0;
                    rx_bit <= rx_bit + 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
                if (rx_cnt == CW'(HALF)) begin
                    if (rx_bit == 4'd0) begin
                        // start bit gone high again: glitch, not a frame
                        if (rx_s) rx_busy <= 1'b0;
                    end else if (rx_bit == 4'd9) begin
                        rx_busy <= 1'b0;
                        if (rx_s) rx_valid <= 1'b1;
                        else      rx_ferr  <= 1'b1;
                    end else begin
                        rx_sh <= {rx_s, rx_sh[7:1]};
                    end
                end
            end
        end
    end

    // Transmitter: ready in the last stop-bit clock so frames run back to back
    logic          tx_active, tx_ready_c, tx_load_c;
    logic [7:0]    tx_byte_c;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sh;

    assign tx_ready_c = !tx_active || (tx_cnt == CW'(CLKS_PER_BIT - 1) && tx_bit == 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_tx   <= 1'b1;
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '0;
        end else if (tx_load_c) begin
            uart_tx   <= 1'b0;
            tx_active <= 1'b1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= {1'b1, tx_byte_c};
        end else if (tx_active) begin
            if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                    tx_bit    <= '0;
                    uart_tx   <= 1'b1;
                end else begin
                    tx_bit  <= tx_bit + 4'd1;
                    uart_tx <= tx_sh[0];
                    tx_sh   <= {1'b1, tx_sh[8:1]};
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

    // Bus cycle termination: slave ack or watchdog expiry
    logic bus_ack_c, to_hit_c, bus_end_c;
    assign bus_ack_c = wb_cyc && wb_ack;
    assign bus_end_c = bus_ack_c || to_hit_c;

`ifdef UARTBONE_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        wd_cnt <= '0;
        else if (wb_cyc && !bus_end_c)  wd_cnt <= wd_cnt + WDW'(1);
        else                            wd_cnt <= '0;
    end

    assign to_hit_c = wb_cyc && !wb_ack && (wd_cnt == WDW'(TIMEOUT - 1));
`else
    assign to_hit_c = 1'b0;
`endif

    logic                cmd_wr_q;
    logic [7:0]          words_q;
    logic [3:0]          byte_cnt_q;
    logic [23:0]         addr_sh_q;
    logic [DATA_W-1:0]   rd_sh_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (rx_valid && (rx_sh == CMD_WR || rx_sh == CMD_RD)) state_d = S_LEN;
            S_LEN:     if (rx_valid) state_d = S_ADDR;
            S_ADDR:    if (rx_valid && byte_cnt_q == 4'd3) begin
                           if (words_q == 8'd0) state_d = S_IDLE;
                           else if (cmd_wr_q)   state_d = S_WDATA;
                           else                 state_d = S_WB_RD;
                       end
            S_WDATA:   if (rx_valid && byte_cnt_q == 4'(BYTES - 1)) state_d = S_WB_WR;
            S_WB_WR:   if (bus_end_c) state_d = (words_q == 8'd1) ? S_IDLE : S_WDATA;
            S_WB_RD:   if (bus_end_c) state_d = S_TX_DATA;
            S_TX_DATA: if (byte_cnt_q == 4'(BYTES) && tx_ready_c)
                           state_d = (words_q == 8'd0) ? S_IDLE : S_WB_RD;
            default:   state_d = S_IDLE;
        endcase
        // a framing error abandons any command still being received
        if (rx_ferr && (state_q == S_IDLE || state_q == S_LEN ||
                        state_q == S_ADDR || state_q == S_WDATA))
            state_d = S_IDLE;
    end

    always_comb begin
        tx_load_c = 1'b0;
        tx_byte_c = rd_sh_q[DATA_W-1 -: 8];
        if (state_q == S_TX_DATA && byte_cnt_q != 4'(BYTES) && tx_ready_c)
            tx_load_c = 1'b1;
    end

    // Datapath and registered bus strobes decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            wb_we      <= 1'b0;
            wb_adr     <= '0;
            wb_dat_w   <= '0;
            cmd_wr_q   <= 1'b0;
            words_q    <= '0;
            byte_cnt_q <= '0;
            addr_sh_q  <= '0;
            rd_sh_q    <= '0;
        end else begin
            wb_cyc <= (state_d == S_WB_WR) || (state_d == S_WB_RD);
            wb_stb <= (state_d == S_WB_WR) || (state_d == S_WB_RD);
            wb_we  <= (state_d == S_WB_WR);
            unique case (state_q)
                S_IDLE: if (rx_valid) cmd_wr_q <= (rx_sh == CMD_WR);
                S_LEN: if (rx_valid) begin
                    words_q    <= rx_sh;
                    byte_cnt_q <= '0;
                end
                S_ADDR: if (rx_valid) begin
                    addr_sh_q <= {addr_sh_q[15:0], rx_sh};
                    if (byte_cnt_q == 4'd3) begin
                        wb_adr     <= ADDR_W'({addr_sh_q, rx_sh});
                        byte_cnt_q <= '0;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 4'd1;
                    end
                end
                S_WDATA: if (rx_valid) begin
                    wb_dat_w   <= DATA_W'({wb_dat_w, rx_sh});
                    byte_cnt_q <= (byte_cnt_q == 4'(BYTES - 1)) ? 4'd0 : byte_cnt_q + 4'd1;
                end
                S_WB_WR: if (bus_end_c) begin
                    wb_adr  <= wb_adr + ADDR_W'(1);
                    words_q <= words_q - 8'd1;
                end
                S_WB_RD: if (bus_end_c) begin
                    wb_adr     <= wb_adr + ADDR_W'(1);
                    words_q    <= words_q - 8'd1;
                    rd_sh_q    <= bus_ack_c ? wb_dat_r : '1;
                    byte_cnt_q <= '0;
                end
                S_TX_DATA: if (tx_load_c) begin
                    rd_sh_q    <= rd_sh_q << 8;
                    byte_cnt_q <= byte_cnt_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uartbone_bridge.sv
// Directed bench for uartbone_bridge: UART host driver, TX frame monitor and a Wishbone slave model.
module tb_uartbone_bridge;

    localparam int unsigned CPB = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 30;
    localparam int unsigned TO  = 16;

    logic          clk, rst, uart_rx, uart_tx;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_dat_w, wb_dat_r;
    logic [3:0]    wb_sel;
    logic          wb_cyc, wb_stb, wb_we, wb_ack;

    uartbone_bridge #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_sel(wb_sel),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int cyc_n      = 0;
    int cyc_clks   = 0;
    logic [31:0] bus_adr[$];
    logic [31:0] bus_dat[$];
    logic        bus_we[$];

    always @(posedge clk) begin
        cyc_n++;
        if (wb_cyc) cyc_clks++;
        if (wb_cyc && wb_stb && wb_ack) begin
            bus_adr.push_back(32'(wb_adr));
            bus_dat.push_back(wb_dat_w);
            bus_we.push_back(wb_we);
        end
    end

    // Slave: ack one clock after strobe, driven on the falling edge
    logic        ack_en = 1'b1;
    logic [31:0] rd_vals[2] = '{32'hDEADBEEF, 32'hCAFEF00D};
    int          rd_idx = 0;

    always @(negedge clk) begin
        if (wb_cyc && wb_stb && !wb_ack && ack_en) begin
            wb_ack   = 1'b1;
            wb_dat_r = rd_vals[rd_idx % 2];
            if (!wb_we) rd_idx++;
        end else begin
            wb_ack = 1'b0;
        end
    end

    // TX monitor: decodes 8N1 frames and records each frame's start clock
    logic [7:0] rx_q[$];
    int         start_q[$];

    initial begin : tx_mon
        logic [7:0] b;
        int st;
        forever begin
            @(negedge uart_tx);
            st = cyc_n;
            repeat (CPB / 2) @(posedge clk);
            #1 check("tx_start_bit", uart_tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 b[i] = uart_tx;
            end
            repeat (CPB) @(posedge clk);
            #1 check("tx_stop_bit", uart_tx, 1'b1);
            rx_q.push_back(b);
            start_q.push_back(st);
        end
    end

    logic [7:0] pkt[$];

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i], 1'b1);
    endtask

    task automatic wait_bus(input int n, input string tag);
        int t = 0;
        while (bus_adr.size() < n && t < 4000) begin
            @(posedge clk);
            t++;
        end
        check(tag, bus_adr.size(), n);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int t = 0;
        while (rx_q.size() < n && t < 20000) begin
            @(posedge clk);
            t++;
        end
        check(tag, rx_q.size(), n);
    endtask

    task automatic reset_on_cyc();
        int t = 0;
        while (!wb_cyc && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check("rst_cyc_seen", wb_cyc, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_cyc", wb_cyc, 1'b0);
        check("rst_async_stb", wb_stb, 1'b0);
        check("rst_async_tx", uart_tx, 1'b1);
        check("rst_async_adr", wb_adr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b[8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        rst = 1'b1;
        uart_rx = 1'b1;
        wb_ack = 1'b0;
        wb_dat_r = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", uart_tx, 1'b1);
        check("rst_cyc", wb_cyc, 1'b0);
        check("rst_stb", wb_stb, 1'b0);
        check("rst_we", wb_we, 1'b0);
        check("rst_adr", wb_adr, 0);
        check("rst_dat_w", wb_dat_w, 0);
        check("rst_sel", wb_sel, 4'hF);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // single-word write
        pkt = '{8'h01, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        send_pkt();
        wait_bus(1, "wr1_count");
        check("wr1_adr", bus_adr[0], 32'h0400_0000);
        check("wr1_dat", bus_dat[0], 32'h1234_5678);
        check("wr1_we", bus_we[0], 1'b1);
        repeat (5) @(negedge clk);
        check("wr1_cyc_low", wb_cyc, 1'b0);
        check("wr1_cyc_clks", cyc_clks, 1);

        // two-word read, data returned MSB first
        pkt = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h24, 8'h00};
        send_pkt();
        wait_bus(3, "rd2_count");
        wait_tx(8, "rd2_tx_count");
        check("rd2_adr0", bus_adr[1], 32'h0000_2400);
        check("rd2_adr1", bus_adr[2], 32'h0000_2401);
        check("rd2_we0", bus_we[1], 1'b0);
        check("rd2_we1", bus_we[2], 1'b0);
        for (int i = 0; i < 8; i++)
            check($sformatf("rd2_byte%0d", i), rx_q[i], exp_b[i]);
        check("rd2_frame_gap", start_q[1] - start_q[0], 10 * CPB);

        // framing error on the third byte, then a clean write
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h04, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("ferr_no_cycle", bus_adr.size(), 3);
        pkt = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'hA5, 8'hA5, 8'h00, 8'h01};
        send_pkt();
        wait_bus(4, "ferr_next_count");
        check("ferr_next_adr", bus_adr[3], 32'h0000_0010);
        check("ferr_next_dat", bus_dat[3], 32'hA5A5_0001);

        // address wrap at the top of the 30-bit space
        pkt = '{8'h01, 8'h02, 8'h3F, 8'hFF, 8'hFF, 8'hFF,
                8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
        send_pkt();
        wait_bus(6, "wrap_count");
        check("wrap_adr0", bus_adr[4], 32'h3FFF_FFFF);
        check("wrap_dat0", bus_dat[4], 32'h1111_1111);
        check("wrap_adr1", bus_adr[5], 32'h0000_0000);
        check("wrap_dat1", bus_dat[5], 32'h2222_2222);

        // stray byte in IDLE, then a zero-length read
        pkt = '{8'h55, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
        send_pkt();
        repeat (200) @(negedge clk);
        check("n0_no_cycle", bus_adr.size(), 6);
        check("n0_no_tx", rx_q.size(), 8);
        check("n0_cyc_low", wb_cyc, 1'b0);

        // read that the slave never acks
        ack_en = 1'b0;
        cyc_clks = 0;
        pkt = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h20};
        send_pkt();
`ifdef UARTBONE_TIMEOUT_EN
        wait_tx(12, "to_tx_count");
        check("to_cyc_clks", cyc_clks, TO);
        check("to_cyc_low", wb_cyc, 1'b0);
        check("to_no_ack", bus_adr.size(), 6);
        check("to_adr_next", wb_adr, 30'h21);
        for (int i = 8; i < 12; i++)
            check($sformatf("to_byte%0d", i - 8), rx_q[i], 8'hFF);
        pkt = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h30};
        fork
            send_pkt();
            reset_on_cyc();
        join
`else
        repeat (200) @(negedge clk);
        check("noto_cyc_high", wb_cyc, 1'b1);
        check("noto_stb_high", wb_stb, 1'b1);
        check("noto_we_low", wb_we, 1'b0);
        check("noto_adr", wb_adr, 30'h20);
        check("noto_no_tx", rx_q.size(), 8);
        reset_on_cyc();
`endif

        // bridge usable again after the mid-cycle reset
        ack_en = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        pkt = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40, 8'hCA, 8'hFE, 8'h00, 8'h01};
        send_pkt();
        wait_bus(7, "post_rst_count");
        check("post_rst_adr", bus_adr[6], 32'h0000_0040);
        check("post_rst_dat", bus_dat[6], 32'hCAFE_0001);
        check("post_rst_we", bus_we[6], 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uartbone_bridge.md
UARTBONE_BRIDGE -- requirements
Module: uartbone_bridge

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, system clocks per UART bit (115200 baud at 100 MHz).
REQ-002 SHALL have parameter DATA_W, default 32, Wishbone data width; a multiple of 8, range 8..64.
REQ-003 SHALL have parameter ADDR_W, default 30, Wishbone word-address width, range 1..32.
REQ-004 SHALL have parameter TIMEOUT, default 1024, ack watchdog limit in clocks; used only under UARTBONE_TIMEOUT_EN.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port uart_rx, input, 1, asynchronous serial input, 8N1, idle high.
REQ-008 SHALL have port uart_tx, output, 1, serial output, 8N1, idle high.
REQ-009 SHALL have Wishbone master ports: wb_adr (output, ADDR_W), wb_dat_w (output, DATA_W), wb_dat_r (input, DATA_W), wb_sel (output, DATA_W/8, all ones), wb_cyc, wb_stb, wb_we (outputs, 1), wb_ack (input, 1).

Function
REQ-010 SHALL pass uart_rx through a 2-flop synchroniser, detect a start bit on a falling edge, and sample every bit at CLKS_PER_BIT/2 into the bit period, LSB first.
REQ-011 SHALL discard any received byte whose stop bit samples 0 (framing error) and return the command FSM to IDLE.
REQ-012 SHALL run the command FSM through states IDLE, LEN, ADDR, WDATA, WB_WR, WB_RD and TX_DATA.
REQ-013 In IDLE, a received byte 0x01 (write) or 0x02 (read) SHALL latch the command and go to LEN; any other byte SHALL be ignored.
REQ-014 In LEN, the received byte SHALL be latched as word count N (0..255); the FSM then goes to ADDR.
REQ-015 ADDR SHALL accept 4 bytes, MSB first; wb_adr SHALL be loaded from bits [ADDR_W-1:0] of the 32-bit value.
REQ-016 N=0 SHALL finish the command after the address bytes with no bus cycle and no response bytes.
REQ-017 For a write, WDATA SHALL assemble DATA_W/8 bytes MSB first, then WB_WR SHALL assert cyc=stb=we=1 with wb_dat_w held until the clock edge where wb_ack=1.
REQ-018 For a read, WB_RD SHALL assert cyc=stb=1 and we=0, and capture wb_dat_r on the ack edge.
REQ-019 After a read ack, TX_DATA SHALL transmit DATA_W/8 bytes MSB first, back to back, then issue the next read.
REQ-020 wb_cyc and wb_stb SHALL deassert in the cycle after ack; there SHALL be no pipelined or overlapping cycles.
REQ-021 After each word, wb_adr SHALL increment by 1, wrapping modulo 2^ADDR_W; after N words the FSM returns to IDLE.
REQ-022 Bytes received during WB_WR, WB_RD or TX_DATA SHALL be dropped.
REQ-023 uart_tx bit period SHALL be exactly CLKS_PER_BIT clocks; each transmitted frame SHALL be 10 bits.

Reset
REQ-024 Reset SHALL force uart_tx=1, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_dat_w=0, wb_sel all ones, FSM=IDLE, all counters 0.
REQ-025 Reset asserted mid-transaction SHALL drop cyc/stb immediately (asynchronously), abort any TX frame, and discard partial input.

Configuration
REQ-026 With UARTBONE_TIMEOUT_EN defined, a bus cycle unacked for TIMEOUT clocks SHALL terminate.
REQ-027 On such a timeout, a read SHALL return all-ones data bytes; a write SHALL be dropped; addressing and the word count SHALL continue as for an acked cycle.
REQ-028 With UARTBONE_TIMEOUT_EN undefined, the bridge SHALL wait for ack indefinitely and SHALL contain no watchdog counter.

Verification
REQ-029 Write, N=1: bytes 01 01 04 00 00 00 12 34 56 78 -> one cycle with wb_adr=0x04000000, wb_dat_w=0x12345678, we=1.
REQ-030 Read, N=2: bytes 02 02 00 00 24 00 with slave returning 0xDEADBEEF then 0xCAFEF00D -> adr 0x2400 then 0x2401; tx DE AD BE EF CA FE F0 0D.
REQ-031 Write with a stop bit forced 0 on the 3rd byte -> no bus cycle; the next well-formed command executes normally.
REQ-032 Write N=2 at address 0x3FFFFFFF (ADDR_W=30) -> second cycle uses wb_adr=0x00000000.
REQ-033 Read with slave never acking, TIMEOUT_EN defined, TIMEOUT=16 -> cyc drops after 16 clocks and tx sends FF FF FF FF; with the macro undefined, cyc stays high.
REQ-034 rst pulsed while wb_cyc=1 -> cyc/stb low in the same cycle, uart_tx=1, and the next command works.
